// File: rtl/stage_sequencer_pkg.sv
// Shared stage encoding for the sequencer and the downstream control path.
// The stage code is the sequencer's state register, so these values are the hardware encoding.
package stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DECODE  = 2'b10,
        ST_EXECUTE = 2'b11
    } stage_t;

    localparam int DEFAULT_INSTR_W = 12;

endpackage

// File: rtl/stage_sequencer.sv
// Stage sequencer: program-load handshake, then FETCH/DECODE/EXECUTE with run/halt
// gating and sticky reload requests, both resolved only at the FETCH boundary.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               pmem_we,
    output logic [ADDR_W-1:0]  pmem_waddr,
    output logic [INSTR_W-1:0] pmem_wdata,
    input  logic               run_en,
    input  logic               reload_req,
    output logic [1:0]         stage,
    output logic               load_done,
    output logic               halted,
    output logic [ADDR_W:0]    load_count,
    output logic [CNT_W-1:0]   instr_count
);

    stage_t             stage_q, stage_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    load_count_q, load_count_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               reload_pend_q, reload_pend_d;
    logic               load_done_q, load_done_d;
    logic               accept;

    assign load_ready  = (stage_q == ST_LOAD);
    assign accept      = load_valid & load_ready;
    assign pmem_we     = accept;
    assign pmem_waddr  = addr_q;
    assign pmem_wdata  = load_data;
    assign stage       = stage_q;
    assign load_done   = load_done_q;
    assign halted      = (stage_q == ST_FETCH) & ~run_en & ~reload_pend_q;
    assign load_count  = load_count_q;
    assign instr_count = instr_count_q;

    // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        stage_d       = stage_q;
        addr_d        = addr_q;
        load_count_d  = load_count_q;
        instr_count_d = instr_count_q;
        reload_pend_d = reload_pend_q;
        load_done_d   = 1'b0;

        case (stage_q)
            ST_LOAD: begin
                // A filled address space ends the load even without load_last.
                if (accept) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    load_count_d = load_count_q + (ADDR_W + 1)'(1);
                    if (load_last || (&addr_q)) begin
                        stage_d     = ST_FETCH;
                        load_done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (reload_pend_q) begin
                    stage_d       = ST_LOAD;
                    reload_pend_d = 1'b0;
                    addr_d        = '0;
                    load_count_d  = '0;
                end else begin
                    if (reload_req) reload_pend_d = 1'b1;
                    if (run_en) stage_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (reload_req) reload_pend_d = 1'b1;
                stage_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (reload_req) reload_pend_d = 1'b1;
                instr_count_d = instr_count_q + CNT_W'(1);
                stage_d       = ST_FETCH;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously; the reset branch clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= ST_LOAD;
            addr_q        <= '0;
            load_count_q  <= '0;
            instr_count_q <= '0;
            reload_pend_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            addr_q        <= addr_d;
            load_count_q  <= load_count_d;
            instr_count_q <= instr_count_d;
            reload_pend_q <= reload_pend_d;
            load_done_q   <= load_done_d;
        end
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Generates the 2-bit `stage` code that drives the control path. Owns the program-load handshake that fills program memory after reset or on request. Sequences LOAD → FETCH → DECODE → EXECUTE, and provides run/halt gating at the FETCH boundary. Sits directly upstream of the control path, beside the program memory write port.

## Interface
- `ADDR_W`, default 8: program memory address width.
- `INSTR_W`, default 12: instruction word width.
- `CNT_W`, default 16: executed-instruction counter width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: a load word is present on `load_data`.
- `load_data` in INSTR_W: instruction word to store.
- `load_last` in 1: qualifies `load_data` as the final word of the program.
- `load_ready` out 1: high while in LOAD.
- `pmem_we` out 1: program memory write strobe; equals `load_valid & load_ready`.
- `pmem_waddr` out ADDR_W: write address; equals the internal load address counter.
- `pmem_wdata` out INSTR_W: write data; equals `load_data` (combinational pass-through).
- `run_en` in 1: level; 0 holds the core at FETCH.
- `reload_req` in 1: single-cycle request to re-enter LOAD.
- `stage` out 2: LOAD=00, FETCH=01, DECODE=10, EXECUTE=11.
- `load_done` out 1: registered one-cycle pulse in the first FETCH cycle after LOAD; the datapath clears PC on it.
- `halted` out 1: `stage==FETCH & !run_en & !reload_pend`.
- `load_count` out ADDR_W+1: number of words accepted in the most recent load.
- `instr_count` out CNT_W: number of EXECUTE cycles completed since reset; wraps.

## Operation
- State register is `stage` itself; no other encoding.
- LOAD:
  - A word is accepted on `load_valid & load_ready`.
  - On accept: the address counter increments and `load_count` increments.
  - The final accept moves to FETCH. An accept is final when `load_last=1` or the address counter equals 2^ADDR_W−1.
  - Otherwise the state stays in LOAD. An empty program is impossible; at least one word is required.
- FETCH is the single decision point, in priority order:
  - If `reload_pend`: go to LOAD, clear `reload_pend`, zero the address counter and `load_count`.
  - Else if `run_en`: go to DECODE.
  - Else stay in FETCH. This is safe because the FETCH re-latch of IR from an unchanged PC is idempotent.
- DECODE → EXECUTE unconditionally.
- EXECUTE → FETCH unconditionally; `instr_count` increments (modulo 2^CNT_W).
- `reload_req` sets the sticky `reload_pend` in FETCH, DECODE or EXECUTE. It is ignored in LOAD.
  - A request arriving during DECODE/EXECUTE lets the current instruction complete. That is followed by exactly one FETCH cycle, then LOAD.
- `run_en` is sampled only in FETCH. Deassertion during DECODE/EXECUTE does not abort the instruction.
- `reload_pend` has priority over `run_en=0`: a halted core still reloads.

## Timing
- Reset (async assert, sync release) values:
  - `stage`=00 (LOAD), `load_ready`=1.
  - Address counter 0, `load_count` 0, `instr_count` 0.
  - `reload_pend` 0, `load_done` 0, `halted` 0.
- Reset asserted mid-instruction or mid-load: everything returns to the values above immediately. A partial program is not reused; it is overwritten by the next load from address 0.
- Load throughput: one word per cycle while `load_valid` is held high.
- The final accept at edge N gives `stage`=01 and `load_done`=1 in cycle N+1; `load_done`=0 from cycle N+2.
- Steady state: 3 cycles per instruction (FETCH, DECODE, EXECUTE), zero bubbles while `run_en=1`.
- Reload latency: a `reload_req` in cycle t during EXECUTE gives FETCH at t+1 and LOAD at t+2.
- `pmem_we`, `pmem_waddr` and `pmem_wdata` are combinational from the current state and inputs. The memory samples them at the same edge that advances the counter.

## Structure
- Shared package (also imported by the control path):
  - stage constants `ST_LOAD`, `ST_FETCH`, `ST_DECODE`, `ST_EXECUTE`;
  - a 2-bit stage typedef;
  - `INSTR_W` default.
- No sub-module: one FSM `always` block plus three inline counters (load address, `load_count`, `instr_count`) and the `reload_pend` flop.

## Test plan
- Reset → `stage`=00, `load_ready`=1, all counts 0.
  - Load 0x801, 0x202, 0x103 with `load_last` on the third word.
  - Expect writes to addresses 0,1,2, `load_count`=3, `load_done` pulse, `stage`=01.
- `run_en`=1 for 9 cycles after load → `stage` sequence 01,10,11 ×3 and `instr_count`=3.
- `run_en`=0 asserted during DECODE → EXECUTE completes. `stage` then holds 01 with `halted`=1. Re-asserting `run_en` gives DECODE next cycle.
- `reload_req` pulse during DECODE with `run_en`=0:
  - Expect EXECUTE, then one FETCH, then `stage`=00.
  - `pmem_waddr`=0, `load_count`=0.
  - `halted` stays 0 throughout.
- 256 back-to-back words, never `load_last` → last write at address 255, `load_count`=256, transition to FETCH.
- Assert `rst_n`=0 asynchronously mid-EXECUTE (between edges) → `stage`=00 and `instr_count`=0 without waiting for a clock edge.
